flex_updown_counter: RTL and testbench

Parametrised up/down successor to the team's flex counter. Counts between 1 and a runtime rollover value in either direction, with synchronous clear and parallel load, and holds its value when idle. It produces a registered terminal-count flag, a one-cycle wrap pulse and a saturating wrap counter. It is the general-purpose timing and sequencing counter for the next-generation datapath and control blocks, and can be cascaded through `wrap_pulse`.

---
 rtl/flex_updown_counter.sv | 155 +++++++++++++++
 tb/tb_flex_updown_counter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// flex_updown_counter: up/down counter between 1 and a runtime rollover value.
// Provides synchronous clear and parallel load, and holds its value when idle.
// Outputs are a registered terminal-count flag, a one-cycle wrap pulse and a
// saturating wrap counter. Stages cascade by feeding wrap_pulse of one stage
// into count_enable of the next.
module flex_updown_counter #(
  parameter int NUM_CNT_BITS  = 4,
  parameter int NUM_WRAP_BITS = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     load,
  input  logic [NUM_CNT_BITS-1:0]  load_val,
  input  logic                     count_enable,
  input  logic                     count_dir,
  input  logic [NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CNT_BITS-1:0]  count_out,
  output logic                     rollover_flag,
  output logic                     wrap_pulse,
  output logic [NUM_WRAP_BITS-1:0] wrap_count
);

  if (NUM_CNT_BITS < 2) begin : g_bad_cnt_bits
    $error("flex_updown_counter: NUM_CNT_BITS must be at least 2");
  end
  if (NUM_WRAP_BITS < 1) begin : g_bad_wrap_bits
    $error("flex_updown_counter: NUM_WRAP_BITS must be at least 1");
  end

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_WRAP_BITS-1:0] WRAP_ONE = NUM_WRAP_BITS'(1);
  localparam logic [NUM_WRAP_BITS-1:0] WRAP_MAX = '1;

  // Registered state. dir_q: 1 = up, 0 = down; it remembers the direction
  // last sampled with count_enable or load.
  logic [NUM_CNT_BITS-1:0]  count_q, count_d;
  logic                     dir_q, dir_d;
  logic                     flag_q, flag_d;
  logic                     pulse_q, pulse_d;
  logic [NUM_WRAP_BITS-1:0] wrap_cnt_q, wrap_cnt_d;

  // Candidate results for the enabled-count path.
  logic [NUM_CNT_BITS-1:0]  step_count;
  logic                     step_wrap;
  logic                     step_flag;
  logic                     load_flag;
  logic [NUM_WRAP_BITS-1:0] wrap_cnt_inc;

  // Terminal value is rollover_val going up and 1 going down. A zero
  // rollover disables the flag entirely, so a parked counter never reports
  // a terminal count.
  function automatic logic term_hit(
    input logic [NUM_CNT_BITS-1:0] val,
    input logic                    dir,
    input logic [NUM_CNT_BITS-1:0] rv
  );
    logic [NUM_CNT_BITS-1:0] term;
    term = dir ? rv : CNT_ONE;
    return (rv != CNT_ZERO) && (val == term);
  endfunction

  // Next count for one enabled step, in the freshly sampled direction.
  // Up wraps on >= so a shrinking rollover never runs past the top; down
  // never decrements 0 and snaps an out-of-range count back to the rollover.
  always_comb begin
    step_count = count_q;
    step_wrap  = 1'b0;
    if (rollover_val == CNT_ZERO) begin
      step_count = CNT_ZERO;
    end else if (count_dir) begin
      if (count_q >= rollover_val) begin
        step_count = CNT_ONE;
        step_wrap  = 1'b1;
      end else begin
        step_count = count_q + CNT_ONE;
      end
    end else begin
      if (count_q == CNT_ONE) begin
        step_count = rollover_val;
        step_wrap  = 1'b1;
      end else if ((count_q == CNT_ZERO) || (count_q > rollover_val)) begin
        step_count = rollover_val;
      end else begin
        step_count = count_q - CNT_ONE;
      end
    end
  end

  // Flag candidates are derived from the value about to be registered so
  // the flag lines up with the new count instead of lagging by a cycle.
  always_comb begin
    step_flag = term_hit(step_count, count_dir, rollover_val);
    load_flag = term_hit(load_val, count_dir, rollover_val);
  end

  // Saturating increment of the wrap counter.
  always_comb begin
    wrap_cnt_inc = wrap_cnt_q;
    if (wrap_cnt_q != WRAP_MAX) begin
      wrap_cnt_inc = wrap_cnt_q + WRAP_ONE;
    end
  end

  // Next-state selection: clear > load > count_enable > hold. The pulse
  // defaults low so it only survives the cycle after a wrap edge.
  always_comb begin
    count_d    = count_q;
    dir_d      = dir_q;
    flag_d     = flag_q;
    pulse_d    = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    if (clear) begin
      count_d    = CNT_ZERO;
      flag_d     = 1'b0;
      wrap_cnt_d = '0;
    end else if (load) begin
      count_d = load_val;
      dir_d   = count_dir;
      flag_d  = load_flag;
    end else if (count_enable) begin
      count_d = step_count;
      dir_d   = count_dir;
      flag_d  = step_flag;
      pulse_d = step_wrap;
      if (step_wrap) begin
        wrap_cnt_d = wrap_cnt_inc;
      end
    end
  end

  // State registers; reset returns to zero count, counting up.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q    <= CNT_ZERO;
      dir_q      <= 1'b1;
      flag_q     <= 1'b0;
      pulse_q    <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      dir_q      <= dir_d;
      flag_q     <= flag_d;
      pulse_q    <= pulse_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign wrap_pulse    = pulse_q;
  assign wrap_count    = wrap_cnt_q;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Bench for flex_updown_counter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model. A second instance with a
// 2-bit wrap counter shares the same stimulus to exercise saturation.
module tb_flex_updown_counter;
  localparam int CW = 4;
  localparam int WW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          clear, load, count_enable, count_dir;
  logic [CW-1:0] load_val, rollover_val;

  logic [CW-1:0] count_out, s_count_out;
  logic          rollover_flag, s_rollover_flag;
  logic          wrap_pulse, s_wrap_pulse;
  logic [WW-1:0] wrap_count;
  logic [SW-1:0] s_wrap_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit up;
    bit flag;
    bit pulse;
    int wraps;
  } mstate_t;

  mstate_t m_main, m_sat;

  flex_updown_counter #(.NUM_CNT_BITS(CW), .NUM_WRAP_BITS(WW)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_dir(count_dir), .rollover_val(rollover_val),
    .count_out(count_out), .rollover_flag(rollover_flag), .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count)
  );

  flex_updown_counter #(.NUM_CNT_BITS(CW), .NUM_WRAP_BITS(SW)) dut_sat (
    .clk(clk), .n_rst(n_rst), .clear(clear), .load(load), .load_val(load_val),
    .count_enable(count_enable), .count_dir(count_dir), .rollover_val(rollover_val),
    .count_out(s_count_out), .rollover_flag(s_rollover_flag), .wrap_pulse(s_wrap_pulse),
    .wrap_count(s_wrap_count)
  );

  always #5 clk = ~clk;

  function automatic mstate_t reset_state();
    mstate_t r;
    r.cnt = 0; r.up = 1'b1; r.flag = 1'b0; r.pulse = 1'b0; r.wraps = 0;
    return r;
  endfunction

  function automatic bit at_terminal(input int cnt, input bit up, input int rv);
    if (rv == 0) return 1'b0;
    return up ? (cnt == rv) : (cnt == 1);
  endfunction

  // One clock edge of the counter, straight from its behavioural rules.
  function automatic mstate_t ref_step(input mstate_t s, input int wmax,
                                       input bit clr, input bit ld, input int lv,
                                       input bit en, input bit up, input int rv);
    mstate_t r;
    bit wrapped;
    r = s;
    r.pulse = 1'b0;
    wrapped = 1'b0;
    if (clr) begin
      r.cnt = 0; r.flag = 1'b0; r.wraps = 0;
    end else if (ld) begin
      r.cnt = lv; r.up = up;
      r.flag = at_terminal(r.cnt, r.up, rv);
    end else if (en) begin
      r.up = up;
      if (rv == 0) r.cnt = 0;
      else if (up) begin
        if (s.cnt >= rv) begin r.cnt = 1; wrapped = 1'b1; end
        else r.cnt = s.cnt + 1;
      end else begin
        if (s.cnt == 1) begin r.cnt = rv; wrapped = 1'b1; end
        else if (s.cnt == 0 || s.cnt > rv) r.cnt = rv;
        else r.cnt = s.cnt - 1;
      end
      if (wrapped) begin
        r.pulse = 1'b1;
        r.wraps = (s.wraps + 1 > wmax) ? wmax : s.wraps + 1;
      end
      r.flag = at_terminal(r.cnt, r.up, rv);
    end
    return r;
  endfunction

  task automatic check_one(input string tag, input mstate_t m, input logic [CW-1:0] c,
                           input logic f, input logic p, input logic [WW-1:0] w);
    logic [CW-1:0] ec;
    logic [WW-1:0] ew;
    ec = CW'(m.cnt);
    ew = WW'(m.wraps);
    total++;
    assert (c === ec) else begin
      bad++; $error("FAIL %s count_out observed=%0d expected=%0d", tag, c, ec);
    end
    total++;
    assert (f === m.flag) else begin
      bad++; $error("FAIL %s rollover_flag observed=%b expected=%b", tag, f, m.flag);
    end
    total++;
    assert (p === m.pulse) else begin
      bad++; $error("FAIL %s wrap_pulse observed=%b expected=%b", tag, p, m.pulse);
    end
    total++;
    assert (w === ew) else begin
      bad++; $error("FAIL %s wrap_count observed=%0d expected=%0d", tag, w, ew);
    end
  endtask

  task automatic check_both(input string tag);
    check_one({tag, "/main"}, m_main, count_out, rollover_flag, wrap_pulse, wrap_count);
    check_one({tag, "/sat"}, m_sat, s_count_out, s_rollover_flag, s_wrap_pulse,
              {{(WW-SW){1'b0}}, s_wrap_count});
  endtask

  task automatic expect_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, step both models with the inputs sampled at that edge,
  // then compare just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    m_main = ref_step(m_main, (1 << WW) - 1, clear, load, int'(load_val),
                      count_enable, count_dir, int'(rollover_val));
    m_sat  = ref_step(m_sat, (1 << SW) - 1, clear, load, int'(load_val),
                      count_enable, count_dir, int'(rollover_val));
    #1;
    check_both(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int up_seq[12]  = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    int dn_seq[6]   = '{2, 1, 4, 3, 2, 1};
    int sat_seq[6]  = '{0, 1, 2, 3, 3, 3};

    n_rst = 1'b0; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    count_dir = 1'b1; load_val = '0; rollover_val = 4'd5;
    m_main = reset_state();
    m_sat  = reset_state();
    #12;
    check_both("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Up wrap at rollover 5
    count_dir = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick("up_wrap");
      expect_val("up_seq_count", 32'(count_out), up_seq[i]);
      expect_val("up_seq_flag", 32'(rollover_flag), 32'(up_seq[i] == 5));
      expect_val("up_seq_pulse", 32'(wrap_pulse), 32'(i == 5 || i == 10));
    end
    expect_val("up_wrap_count", 32'(wrap_count), 2);

    // Down wrap from a loaded 3, rollover 4
    count_enable = 1'b0; load = 1'b1; load_val = 4'd3; count_dir = 1'b0; rollover_val = 4'd4;
    tick("dn_load");
    load = 1'b0; count_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("dn_wrap");
      expect_val("dn_seq_count", 32'(count_out), dn_seq[i]);
      expect_val("dn_seq_flag", 32'(rollover_flag), 32'(dn_seq[i] == 1));
      expect_val("dn_seq_pulse", 32'(wrap_pulse), 32'(i == 2));
    end

    // Priority: clear beats load and enable
    count_enable = 1'b0; load = 1'b1; load_val = 4'd3; count_dir = 1'b1;
    tick("pri_load3");
    expect_val("pri_at3", 32'(count_out), 3);
    clear = 1'b1; load = 1'b1; count_enable = 1'b1; load_val = 4'd9;
    tick("pri_all");
    expect_val("pri_clear_count", 32'(count_out), 0);
    expect_val("pri_clear_wraps", 32'(wrap_count), 0);
    expect_val("pri_clear_flag", 32'(rollover_flag), 0);
    clear = 1'b0; count_enable = 1'b0;
    tick("pri_load9");
    expect_val("pri_load9", 32'(count_out), 9);

    // Shrinking rollover, up then down
    load = 1'b1; load_val = 4'd7; count_dir = 1'b1; rollover_val = 4'd10;
    tick("shr_load_up");
    load = 1'b0; rollover_val = 4'd4; count_enable = 1'b1;
    tick("shr_up");
    expect_val("shr_up_count", 32'(count_out), 1);
    expect_val("shr_up_pulse", 32'(wrap_pulse), 1);
    count_enable = 1'b0; load = 1'b1; load_val = 4'd7; count_dir = 1'b0;
    tick("shr_load_dn");
    load = 1'b0; count_enable = 1'b1;
    tick("shr_dn");
    expect_val("shr_dn_count", 32'(count_out), 4);
    expect_val("shr_dn_pulse", 32'(wrap_pulse), 0);

    // Saturation on the 2-bit wrap counter, then zero rollover
    count_enable = 1'b0; clear = 1'b1;
    tick("sat_clear");
    clear = 1'b0; rollover_val = 4'd1; count_dir = 1'b1; count_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick("sat_run");
      expect_val("sat_wraps", 32'(s_wrap_count), sat_seq[i]);
      expect_val("sat_count", 32'(s_count_out), 1);
    end
    rollover_val = 4'd0;
    tick("rv_zero");
    expect_val("rv_zero_count", 32'(s_count_out), 0);
    expect_val("rv_zero_pulse", 32'(s_wrap_pulse), 0);

    // Async reset between edges at count 6
    rollover_val = 4'd10; count_enable = 1'b0; load = 1'b1; load_val = 4'd5; count_dir = 1'b1;
    tick("ar_load5");
    load = 1'b0; count_enable = 1'b1;
    tick("ar_to6");
    expect_val("ar_at6", 32'(count_out), 6);
    count_enable = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    m_main = reset_state();
    m_sat  = reset_state();
    check_both("async_rst");
    @(negedge clk);
    n_rst = 1'b1; count_enable = 1'b1; count_dir = 1'b1;
    tick("ar_resume");
    expect_val("ar_resume_count", 32'(count_out), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      clear        = ($urandom_range(0, 24) == 0);
      load         = ($urandom_range(0, 7) == 0);
      count_enable = ($urandom_range(0, 9) < 7);
      count_dir    = 1'($urandom_range(0, 1));
      load_val     = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) rollover_val = CW'($urandom_range(0, 15));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
